// File: rtl/rv32e_mem_arbiter_pkg.sv
// Shared types and constants for the rv32e memory arbiter.
// State codes (2-bit), transaction owner codes and small helpers.
package rv32e_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    ARB_OWNER_I = 1'b0,
    ARB_OWNER_D = 1'b1
  } arb_owner_e;

  // Starvation counter is 4 bits wide and saturates here
  localparam logic [3:0] STARVE_SAT = 4'hF;

  // Fetches always read a full word
  localparam logic [3:0] FETCH_BE = 4'hF;

  // Saturating 32-bit increment for the optional performance counters
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rv32e_mem_arbiter_watchdog.sv
// Watchdog for the arbiter WAIT state: 8-bit counter that is cleared when a
// request is accepted and counts every WAIT cycle. 'expired' is raised in the
// WAIT cycle that would make the count reach TIMEOUT, so the arbiter leaves
// WAIT after exactly TIMEOUT cycles without a memory response.
import rv32e_mem_arbiter_pkg::*;

module rv32e_mem_arbiter_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  logic [7:0] count;

  // Count WAIT cycles; cleared on reset and whenever a new access is accepted
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  assign expired = enable && (count == LAST_COUNT);

endmodule

// File: rtl/rv32e_mem_arbiter.sv
// rv32e_mem_arbiter: shares one single-port memory between the fetch (I) and
// load/store (D) ports of rv32e_cpu, one transaction in flight.
// D wins arbitration unless I has waited through STARVE_LIMIT D grants.
// A watchdog turns a hung access into an error response with zero data.
// Optional feature macro: MEM_ARB_PERF_EN adds saturating grant/wait counters.
import rv32e_mem_arbiter_pkg::*;

module rv32e_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_i_grants,
  output logic [31:0] perf_d_grants,
  output logic [31:0] perf_i_wait
`endif
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  arb_state_e state;
  arb_state_e state_next;
  arb_owner_e owner;
  logic [3:0] starve;
  logic       grant_i;
  logic       arb_start;
  logic       resp_go;
  logic       wd_clear;
  logic       wd_enable;
  logic       wd_expired;

  // I wins only when D is absent or I has been starved up to the limit
  assign grant_i   = i_req && (!d_req || (starve == STARVE_MAX));
  assign arb_start = (state == ARB_IDLE) && (i_req || d_req);
  assign resp_go   = (state_next == ARB_RESP);
  assign wd_clear  = (state == ARB_ISSUE);
  assign wd_enable = (state == ARB_WAIT);

  rv32e_mem_arbiter_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; memory responses outside ISSUE/WAIT are ignored
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          state_next = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (m_gnt) begin
          state_next = m_rvalid ? ARB_RESP : ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (m_rvalid || wd_expired) begin
          state_next = ARB_RESP;
        end
      end
      ARB_RESP: begin
        state_next = ARB_IDLE;
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // Registered outputs: latch the winner's fields, drive the response pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner    <= ARB_OWNER_I;
      starve   <= 4'd0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_be     <= 4'd0;
      m_addr   <= 32'd0;
      m_wdata  <= 32'd0;
      i_rvalid <= 1'b0;
      i_rdata  <= 32'd0;
      d_rvalid <= 1'b0;
      d_rdata  <= 32'd0;
      err      <= 1'b0;
    end else begin
      m_req <= (state_next == ARB_ISSUE);
      if (arb_start) begin
        if (grant_i) begin
          owner   <= ARB_OWNER_I;
          m_we    <= 1'b0;
          m_be    <= FETCH_BE;
          m_addr  <= i_addr;
          m_wdata <= 32'd0;
          starve  <= 4'd0;
        end else begin
          owner   <= ARB_OWNER_D;
          m_we    <= d_we;
          m_be    <= d_be;
          m_addr  <= d_addr;
          m_wdata <= d_wdata;
          if (i_req && (starve != STARVE_SAT)) begin
            starve <= starve + 4'd1;
          end
        end
      end
      i_rvalid <= resp_go && (owner == ARB_OWNER_I);
      d_rvalid <= resp_go && (owner == ARB_OWNER_D);
      i_rdata  <= (resp_go && (owner == ARB_OWNER_I) && m_rvalid) ? m_rdata : 32'd0;
      d_rdata  <= (resp_go && (owner == ARB_OWNER_D) && m_rvalid) ? m_rdata : 32'd0;
      err      <= resp_go && !m_rvalid;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic i_in_service;

  assign i_in_service = (state != ARB_IDLE) && (owner == ARB_OWNER_I);

  // Saturating grant counters and fetch-wait cycle counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_i_grants <= 32'd0;
      perf_d_grants <= 32'd0;
      perf_i_wait   <= 32'd0;
    end else begin
      if (arb_start && grant_i) begin
        perf_i_grants <= sat_inc32(perf_i_grants);
      end
      if (arb_start && !grant_i) begin
        perf_d_grants <= sat_inc32(perf_d_grants);
      end
      if (i_req && !i_in_service) begin
        perf_i_wait <= sat_inc32(perf_i_wait);
      end
    end
  end
`endif

endmodule

// File: tb/tb_rv32e_mem_arbiter.sv
// Directed testbench for rv32e_mem_arbiter (STARVE_LIMIT=4, TIMEOUT=8).
// Expected responses go into a scoreboard queue when a request is driven and
// are popped and compared whenever the arbiter pulses i_rvalid or d_rvalid.
module tb_rv32e_mem_arbiter;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        err;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  int   checks;
  int   errors;
  logic resp_seen;
  exp_t sb[$];

  rv32e_mem_arbiter #(
    .STARVE_LIMIT (4),
    .TIMEOUT      (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_be     (d_be),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .err      (err),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_be     (m_be),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_gnt    (m_gnt),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic sb_push(input logic is_d, input logic [31:0] data, input logic e);
    exp_t x;
    x.is_d = is_d;
    x.data = data;
    x.err  = e;
    sb.push_back(x);
  endtask

  // Advance one cycle, sample 1 ns after the edge, score any response pulse
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    resp_seen = 1'b0;
    if (i_rvalid || d_rvalid) begin
      resp_seen = 1'b1;
      if (sb.size() == 0) begin
        check_output("unexpected_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_output("rvalid_port_d", 32'(d_rvalid), 32'(e.is_d));
        check_output("rvalid_port_i", 32'(i_rvalid), 32'(!e.is_d));
        check_output("rdata", e.is_d ? d_rdata : i_rdata, e.data);
        check_output("err", 32'(err), 32'(e.err));
      end
    end
  endtask

  task automatic apply_stimulus(input logic dreq, input logic ireq, input logic we,
                                input logic [3:0] be, input logic [31:0] addr,
                                input logic [31:0] wdata);
    d_req   = dreq;
    i_req   = ireq;
    d_we    = we;
    d_be    = be;
    d_addr  = addr;
    d_wdata = wdata;
  endtask

  // Request already driven, state IDLE: immediate grant, response next cycle.
  // Returns right after the response cycle has been sampled.
  task automatic run_txn(input logic exp_d, input logic [31:0] exp_addr, input logic [31:0] rd);
    sb_push(exp_d, rd, 1'b0);
    tick();
    check_output("issue_m_req", 32'(m_req), 32'd1);
    check_output("issue_m_addr", m_addr, exp_addr);
    m_gnt = 1'b1;
    tick();
    check_output("wait_m_req", 32'(m_req), 32'd0);
    m_gnt    = 1'b0;
    m_rvalid = 1'b1;
    m_rdata  = rd;
    tick();
    check_output("resp_latency", 32'(resp_seen), 32'd1);
    m_rvalid = 1'b0;
    m_rdata  = 32'd0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    resp_seen = 1'b0;
    reset     = 1'b0;
    i_req     = 1'b0;
    i_addr    = 32'd0;
    m_gnt     = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = 32'd0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);

    // Reset state
    tick();
    tick();
    check_output("reset_m_req", 32'(m_req), 32'd0);
    check_output("reset_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    check_output("reset_err", 32'(err), 32'd0);
    check_output("reset_m_addr", m_addr, 32'd0);
    check_output("reset_m_be", 32'(m_be), 32'd0);
    reset = 1'b1;
    tick();

    // Lone load, response three cycles after the request
    $display("[TB] lone load");
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'd0);
    run_txn(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
    check_output("load_m_we", 32'(m_we), 32'd0);
    d_req = 1'b0;
    tick();
    check_output("load_pulse_once", 32'(d_rvalid), 32'd0);

    // Store with grant delayed three cycles and a stray m_rvalid in ISSUE
    $display("[TB] store, late grant");
    apply_stimulus(1'b1, 1'b0, 1'b1, 4'b0011, 32'h0000_0200, 32'h1234_5678);
    sb_push(1'b1, 32'd0, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      check_output("store_m_req", 32'(m_req), 32'd1);
      check_output("store_m_we", 32'(m_we), 32'd1);
      check_output("store_m_be", 32'(m_be), 32'h3);
      check_output("store_m_wdata", m_wdata, 32'h1234_5678);
      m_rvalid = (k == 1);
      m_rdata  = (k == 1) ? 32'h0000_0077 : 32'd0;
      tick();
    end
    check_output("store_m_req_held", 32'(m_req), 32'd1);
    check_output("store_no_early_resp", 32'(d_rvalid), 32'd0);
    m_rvalid = 1'b0;
    m_rdata  = 32'd0;
    m_gnt    = 1'b1;
    tick();
    check_output("store_wait_m_req", 32'(m_req), 32'd0);
    m_gnt    = 1'b0;
    m_rvalid = 1'b1;
    tick();
    check_output("store_resp", 32'(resp_seen), 32'd1);
    m_rvalid = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    tick();

    // Fetch with no memory response: watchdog error after 8 WAIT cycles
    $display("[TB] fetch timeout");
    i_req  = 1'b1;
    i_addr = 32'h0000_0300;
    sb_push(1'b0, 32'd0, 1'b1);
    tick();
    check_output("fetch_m_addr", m_addr, 32'h0000_0300);
    check_output("fetch_m_be", 32'(m_be), 32'hF);
    check_output("fetch_m_we", 32'(m_we), 32'd0);
    check_output("fetch_m_wdata", m_wdata, 32'd0);
    m_gnt = 1'b1;
    tick();
    m_gnt   = 1'b0;
    m_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 7; k++) begin
      tick();
    end
    check_output("timeout_not_early", 32'(i_rvalid), 32'd0);
    tick();
    check_output("timeout_resp", 32'(i_rvalid), 32'd1);
    m_rdata = 32'd0;
    i_req   = 1'b0;
    tick();

    // Both requesting continuously: D,D,D,D,I repeating
    $display("[TB] arbitration with starvation limit");
    i_addr = 32'h0000_1000;
    apply_stimulus(1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_2000, 32'd0);
    for (int k = 0; k < 10; k++) begin
      logic exp_d;
      exp_d = ((k % 5) != 4);
      run_txn(exp_d, exp_d ? 32'h0000_2000 : 32'h0000_1000, 32'h1000_0000 + 32'(k));
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    tick();

    // Grant and response in the same ISSUE cycle
    $display("[TB] same-cycle grant and response");
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'hF, 32'h0000_0600, 32'd0);
    sb_push(1'b1, 32'h0BAD_F00D, 1'b0);
    tick();
    m_gnt    = 1'b1;
    m_rvalid = 1'b1;
    m_rdata  = 32'h0BAD_F00D;
    tick();
    check_output("fast_resp", 32'(resp_seen), 32'd1);
    m_gnt    = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = 32'd0;
    d_req    = 1'b0;
    tick();

    // Reset during WAIT, stale response afterwards, then a normal fetch
    $display("[TB] reset during WAIT");
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'hF, 32'h0000_0400, 32'd0);
    tick();
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check_output("abort_m_req", 32'(m_req), 32'd0);
    check_output("abort_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    reset    = 1'b1;
    d_req    = 1'b0;
    m_rvalid = 1'b1;
    m_rdata  = 32'h0000_0055;
    tick();
    m_rvalid = 1'b0;
    m_rdata  = 32'd0;
    tick();
    check_output("abort_no_resp", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    check_output("abort_idle_m_req", 32'(m_req), 32'd0);
    i_req  = 1'b1;
    i_addr = 32'h0000_0500;
    run_txn(1'b0, 32'h0000_0500, 32'hCAFE_F00D);
    i_req = 1'b0;
    tick();
    tick();

    check_output("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
